arm_sc_core: RTL and testbench



---
 rtl/arm_sc_core.sv | 97 +++++++++
 tb/tb_arm_sc_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/arm_sc_core.sv
// arm_sc_core: single-cycle ARMv4-subset core (decoder, condition logic, PC, register file, ALU).
// Every instruction is decoded, executed and retired in the same clock.
module arm_sc_core (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic        MemWrite,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);
  logic [3:0]  cond, rn, rd, rm, cmd, ra1, ra2;
  logic [1:0]  op, alu_ctrl;
  logic        dp, mem, br, cmd_ok, ldr, str, s_bit, reg_src;
  logic        cond_ex, rw_type, reg_write, flag_write, pc_src, is_sub;
  logic        n_f, z_f, c_f, v_f, carry, ovf;
  logic [31:0] pc8, rd1, ext_imm, src_b, b_op, result;
  logic [32:0] sum;
  logic [31:0] rf [0:14];
  assign cond    = Instr[31:28];
  assign op      = Instr[27:26];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign rn      = Instr[19:16];
  assign rd      = Instr[15:12];
  assign rm      = Instr[3:0];
  assign dp      = op == 2'b00;
  assign mem     = op == 2'b01;
  assign br      = op == 2'b10;
  assign ldr     = mem & Instr[20];
  assign str     = mem & ~Instr[20];
  assign reg_src = dp & ~Instr[25];
  assign cmd_ok  = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
  assign alu_ctrl = !dp              ? 2'b00 :
                    cmd == 4'b0100   ? 2'b00 :
                    cmd == 4'b0010   ? 2'b01 :
                    cmd == 4'b0000   ? 2'b10 : 2'b11;
  always_comb begin
    case (cond)
      4'h0:    cond_ex = z_f;
      4'h1:    cond_ex = ~z_f;
      4'h2:    cond_ex = c_f;
      4'h3:    cond_ex = ~c_f;
      4'h4:    cond_ex = n_f;
      4'h5:    cond_ex = ~n_f;
      4'h6:    cond_ex = v_f;
      4'h7:    cond_ex = ~v_f;
      4'h8:    cond_ex = c_f & ~z_f;
      4'h9:    cond_ex = ~c_f | z_f;
      4'ha:    cond_ex = n_f == v_f;
      4'hb:    cond_ex = n_f != v_f;
      4'hc:    cond_ex = ~z_f & (n_f == v_f);
      4'hd:    cond_ex = z_f | (n_f != v_f);
      4'he:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign rw_type    = (dp & cmd_ok) | ldr;
  assign reg_write  = cond_ex & rw_type & ~reset & (rd != 4'd15);
  assign flag_write = cond_ex & dp & cmd_ok & s_bit & ~reset;
  assign MemWrite   = cond_ex & str & ~reset;
  assign pc_src     = cond_ex & (br | (rw_type & rd == 4'd15));
  // R15 reads as PC+8; branches use it as ALU source A
  assign ra1       = br ? 4'd15 : rn;
  assign ra2       = str ? rd : rm;
  assign pc8       = PC + 32'd8;
  assign rd1       = ra1 == 4'd15 ? pc8 : rf[ra1];
  assign WriteData = ra2 == 4'd15 ? pc8 : rf[ra2];
  assign ext_imm = br  ? {{6{Instr[23]}}, Instr[23:0], 2'b00} :
                   mem ? {20'b0, Instr[11:0]} : {24'b0, Instr[7:0]};
  assign src_b   = reg_src ? WriteData : ext_imm;
  assign is_sub  = alu_ctrl == 2'b01;
  assign b_op    = is_sub ? ~src_b : src_b;
  assign sum     = {1'b0, rd1} + {1'b0, b_op} + {32'b0, is_sub};
  assign ALUResult = alu_ctrl[1] ? (alu_ctrl[0] ? rd1 | src_b : rd1 & src_b) : sum[31:0];
  assign carry   = sum[32];
  assign ovf     = (rd1[31] == b_op[31]) & (sum[31] ^ rd1[31]);
  assign result  = ldr ? ReadData : ALUResult;
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= 32'd0;
      {n_f, z_f, c_f, v_f} <= 4'b0000;
    end else begin
      PC <= pc_src ? result : PC + 32'd4;
      if (flag_write) begin
        n_f <= ALUResult[31];
        z_f <= ALUResult == 32'd0;
        c_f <= alu_ctrl[1] ? 1'b0 : carry;
        v_f <= alu_ctrl[1] ? 1'b0 : ovf;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reg_write) rf[rd] <= result;
  end
endmodule

// File: tb/tb_arm_sc_core.sv
// tb_arm_sc_core: directed test-plan program plus random instruction stream against an ISA-level model.
module tb_arm_sc_core;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] Instr = 32'hEC000000, ReadData = 32'd0;
  logic [31:0] PC, ALUResult, WriteData;
  logic        MemWrite;
  arm_sc_core dut (.clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .MemWrite(MemWrite),
                   .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_r [0:15];
  bit          m_k [0:15];
  bit          fn, fz, fc, fv;
  logic        o_mw;
  logic [31:0] o_alu, o_wd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rv(input logic [3:0] r);
    return r == 4'd15 ? m_pc + 32'd8 : m_r[r];
  endfunction
  function automatic bit known(input logic [3:0] r);
    return r == 4'd15 || m_k[r];
  endfunction
  function automatic bit pass(input logic [3:0] c);
    case (c)
      4'h0: return fz;        4'h1: return !fz;
      4'h2: return fc;        4'h3: return !fc;
      4'h4: return fn;        4'h5: return !fn;
      4'h6: return fv;        4'h7: return !fv;
      4'h8: return fc && !fz; 4'h9: return !fc || fz;
      4'ha: return fn == fv;  4'hb: return fn != fv;
      4'hc: return !fz && fn == fv;
      4'hd: return fz || fn != fv;
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata, input bit rst);
    logic [3:0] c, rn, rd, rm, cmd;
    logic [1:0] op;
    logic [31:0] a, b, res, tgt, nxt, val;
    logic [32:0] wide;
    bit ok, dpv, ld, st, ib, rk;
    @(negedge clk);
    Instr = ins; ReadData = rdata; reset = rst;
    #1;
    o_mw = MemWrite; o_alu = ALUResult; o_wd = WriteData;
    c = ins[31:28]; op = ins[27:26]; cmd = ins[24:21];
    rn = ins[19:16]; rd = ins[15:12]; rm = ins[3:0]; ib = ins[25];
    ok  = pass(c);
    dpv = op == 2'd0 && (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12);
    ld  = op == 2'd1 && ins[20];
    st  = op == 2'd1 && !ins[20];
    a   = rv(rn);
    b   = op == 2'd1 ? {20'd0, ins[11:0]} : ib ? {24'd0, ins[7:0]} : rv(rm);
    res = cmd == 4'd4 ? a + b : cmd == 4'd2 ? a - b : cmd == 4'd0 ? a & b : a | b;
    rk  = known(rn) && (ib || known(rm));
    tgt = m_pc + 32'd8 + {{6{ins[23]}}, ins[23:0], 2'b00};
    chk("memwrite", {31'd0, o_mw}, {31'd0, !rst && ok && st});
    if (known(st ? rd : rm)) chk("writedata", o_wd, rv(st ? rd : rm));
    if (dpv && rk) chk("alu_dp", o_alu, res);
    if (op == 2'd1 && known(rn)) chk("alu_mem", o_alu, a + b);
    if (op == 2'd2) chk("alu_br", o_alu, tgt);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'd0;
      {fn, fz, fc, fv} = 4'b0000;
    end else begin
      nxt = m_pc + 32'd4;
      if (ok) begin
        if (dpv || ld) begin
          val = ld ? rdata : res;
          if (rd == 4'd15) nxt = val;
          else begin
            m_r[rd] = val;
            m_k[rd] = ld || rk;
          end
        end
        if (dpv && ins[20]) begin
          fn = res[31];
          fz = res == 32'd0;
          if (cmd == 4'd4) begin
            wide = {1'b0, a} + {1'b0, b};
            fc = wide[32];
            fv = a[31] == b[31] && res[31] != a[31];
          end else if (cmd == 4'd2) begin
            fc = a >= b;
            fv = a[31] != b[31] && res[31] != a[31];
          end else begin
            fc = 1'b0;
            fv = 1'b0;
          end
        end
        if (op == 2'd2) nxt = tgt;
      end
      m_pc = nxt;
    end
    #1;
    chk("pc", PC, m_pc);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [3:0] c, rd, cmd;
    int o;
    logic [23:0] off;
    c  = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'hE;
    rd = $urandom_range(0, 19) == 0 ? 4'd15 : 4'($urandom_range(0, 14));
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: begin
        case ($urandom_range(0, 4))
          0: cmd = 4'd4; 1: cmd = 4'd2; 2: cmd = 4'd0; 3: cmd = 4'd12;
          default: cmd = 4'($urandom_range(0, 15));
        endcase
        if ($urandom_range(0, 1) == 1)
          return {c, 3'b001, cmd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd,
                  12'($urandom_range(0, 4095))};
        return {c, 3'b000, cmd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd,
                8'd0, 4'($urandom_range(0, 15))};
      end
      5, 6, 7: return {c, 3'b010, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), rd, 12'($urandom_range(0, 4095))};
      8: begin
        o = int'($urandom_range(0, 16)) - 8;
        off = o[23:0];
        return {c, 4'b1010, off};
      end
      default: return {c, 2'b11, 26'($urandom_range(0, 32'h3FFFFFF))};
    endcase
  endfunction
  initial begin
    for (int i = 0; i < 16; i++) m_k[i] = 1'b0;
    step(32'hE5802064, 32'd0, 1'b1);
    step(32'hE5802064, 32'd0, 1'b1);
    chk("reset_pc", PC, 32'd0);
    chk("reset_mw", {31'd0, o_mw}, 32'd0);
    step(32'hEC000000, 32'd0, 1'b0); chk("fetch4", PC, 32'd4);
    step(32'hEC000000, 32'd0, 1'b0); chk("fetch8", PC, 32'd8);
    step(32'hEC000000, 32'd0, 1'b0); chk("fetch12", PC, 32'd12);
    chk("nop_mw", {31'd0, o_mw}, 32'd0);
    step(32'hE04F000F, 32'd0, 1'b0);
    step(32'hE2802005, 32'd0, 1'b0); chk("add_imm", o_alu, 32'd5);
    step(32'hE5802064, 32'd0, 1'b0);
    chk("str_mw", {31'd0, o_mw}, 32'd1);
    chk("str_addr", o_alu, 32'd100);
    chk("str_data", o_wd, 32'd5);
    step(32'hE5903064, 32'd7, 1'b0);
    step(32'hE5803000, 32'd0, 1'b0); chk("ldr_fwd", o_wd, 32'd7);
    step(32'hE2524005, 32'd0, 1'b0);
    step(32'h0A000001, 32'd0, 1'b0); chk("beq_taken", PC, 32'd48);
    step(32'hE2525004, 32'd0, 1'b0);
    step(32'h0A000001, 32'd0, 1'b0); chk("beq_fall", PC, 32'd56);
    step(32'hE2524005, 32'd0, 1'b0);
    step(32'h15802064, 32'd0, 1'b0); chk("strne_mw", {31'd0, o_mw}, 32'd0);
    step(32'h12802009, 32'd0, 1'b0);
    step(32'hE5802000, 32'd0, 1'b0); chk("addne_skip", o_wd, 32'd5);
    step(32'hF2802009, 32'd0, 1'b0);
    step(32'hE5802000, 32'd0, 1'b0); chk("nv_skip", o_wd, 32'd5);
    step(32'hE5906000, 32'h7FFFFFFF, 1'b0);
    step(32'hE2967001, 32'd0, 1'b0); chk("adds_ovf", o_alu, 32'h80000000);
    step(32'h4A000000, 32'd0, 1'b0); chk("bmi_n1", PC, 32'd96);
    step(32'h6A000000, 32'd0, 1'b0); chk("bvs_v1", PC, 32'd104);
    step(32'h2A000000, 32'd0, 1'b0); chk("bcs_c0", PC, 32'd108);
    step(32'hEAFFFFFE, 32'd0, 1'b0); chk("b_self", PC, 32'd108);
    step(32'hE590F000, 32'hFFFFFFFC, 1'b0); chk("ldr_pc", PC, 32'hFFFFFFFC);
    step(32'hEC000000, 32'd0, 1'b0); chk("pc_wrap", PC, 32'd0);
    for (int i = 1; i < 15; i++)
      step({20'hE2800, 4'(i), 4'd0, 8'($urandom_range(0, 255))}, 32'd0, 1'b0);
    step(32'hE2801063, 32'd0, 1'b1); chk("midreset_pc", PC, 32'd0);
    step(32'hE5801000, 32'd0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(rand_instr(), $urandom, $urandom_range(0, 49) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
